keccak_round_ctrl: RTL

KECCAK_ROUND_CTRL -- requirements
Module: keccak_round_ctrl

---
 rtl/keccak_round_ctrl.sv | 100 ++++++++++
 1 files changed

// File: rtl/keccak_round_ctrl.sv
// SHA3-256 sponge controller: absorbs a rate block, then drives 24 Keccak rounds through an external round stage.
// Digest is visible the cycle after the 24th round edge and held until digest_ready; no block is taken outside IDLE.
module keccak_round_ctrl #(
  parameter int WIDTH      = 64,
  parameter int RATE_LANES = 17
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [RATE_LANES*WIDTH-1:0]   blk_data,
  input  logic                          blk_last,
  input  logic                          blk_valid,
  output logic                          blk_ready,
  output logic [0:4][0:4][WIDTH-1:0]    rnd_in,
  output logic [4:0]                    rcs,
  input  logic [0:4][0:4][WIDTH-1:0]    rnd_out,
  output logic [255:0]                  digest,
  output logic                          digest_valid,
  input  logic                          digest_ready
);

  typedef enum logic [1:0] {IDLE, ROUND, OUT} state_t;

  localparam logic [4:0] LAST_RND = 5'd23;

  state_t                       state_q, state_d;
  logic [0:4][0:4][WIDTH-1:0]   s_q, s_d;
  logic [4:0]                   rnd_cnt_q, rnd_cnt_d;
  logic                         last_q, last_d;
  logic [0:4][0:4][WIDTH-1:0]   blk_st;

  // Lane i lands at S[i%5][i/5]; capacity lanes get zeros so the XOR leaves them alone.
  for (genvar gx = 0; gx < 5; gx++) begin : gen_x
    for (genvar gy = 0; gy < 5; gy++) begin : gen_y
      localparam int LANE = 5 * gy + gx;
      if (LANE < RATE_LANES) begin : gen_rate
        assign blk_st[gx][gy] = blk_data[LANE*WIDTH +: WIDTH];
      end else begin : gen_cap
        assign blk_st[gx][gy] = '0;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    rnd_cnt_d    = rnd_cnt_q;
    last_d       = last_q;
    blk_ready    = 1'b0;
    digest_valid = 1'b0;
    rcs          = 5'd0;
    case (state_q)
      IDLE: begin
        blk_ready = 1'b1;
        if (blk_valid) begin
          s_d       = s_q ^ blk_st;
          rnd_cnt_d = 5'd0;
          last_d    = blk_last;
          state_d   = ROUND;
        end
      end
      ROUND: begin
        rcs = rnd_cnt_q;
        s_d = rnd_out;
        if (rnd_cnt_q == LAST_RND) begin
          rnd_cnt_d = 5'd0;
          state_d   = last_q ? OUT : IDLE;
        end else begin
          rnd_cnt_d = rnd_cnt_q + 5'd1;
        end
      end
      OUT: begin
        digest_valid = 1'b1;
        // Clearing S here makes the next accepted block start a fresh message.
        if (digest_ready) begin
          s_d     = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      s_q       <= '0;
      rnd_cnt_q <= 5'd0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      rnd_cnt_q <= rnd_cnt_d;
      last_q    <= last_d;
    end
  end

  assign rnd_in = s_q;
  assign digest = {s_q[3][0], s_q[2][0], s_q[1][0], s_q[0][0]};

endmodule
